// File: rtl/bus_interface_unit.sv
// Wait-state-aware bus master: 3-phase bus cycle with posted writes.
// Reads are held until every earlier buffered write has completed.
module bus_interface_unit #(
  parameter int DATA_W     = 4,
  parameter int ADDR_W     = 4,
  parameter int WBUF_DEPTH = 4,
  parameter int TIMEOUT    = 15
) (
  input  logic              Clk,
  input  logic              Rst,
  input  logic              Req_Valid,
  output logic              Req_Ready,
  input  logic              Req_Wr,
  input  logic [ADDR_W-1:0] Req_Addr,
  input  logic [DATA_W-1:0] Req_Data,
  output logic              Rsp_Valid,
  output logic [DATA_W-1:0] Rsp_Data,
  output logic              Rsp_Err,
  output logic              Wr_Err,
  input  logic              Bus_Grant,
  output logic              Bus_Ale,
  output logic [ADDR_W-1:0] Bus_Addr,
  output logic [DATA_W-1:0] Bus_D_Out,
  output logic              Bus_D_Oe,
  input  logic [DATA_W-1:0] Bus_D_In,
  output logic              Bus_Rd_n,
  output logic              Bus_Wr_n,
  input  logic              Bus_Ready,
  output logic              Busy
);

  localparam int PTR_W = (WBUF_DEPTH < 2) ? 1 : $clog2(WBUF_DEPTH);
  localparam int CNT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_TO  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [PTR_W:0]   WB_FULL = (PTR_W + 1)'(WBUF_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0]   CNT_ONE = (PTR_W + 1)'(1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_T1   = 2'd1;
  localparam logic [1:0] S_T2   = 2'd2;
  localparam logic [1:0] S_T3   = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  wcnt_q, wcnt_d;
  logic              cyc_wr_q, cyc_wr_d;
  logic              cyc_err_q, cyc_err_d;
  logic [ADDR_W-1:0] cyc_addr_q, cyc_addr_d;
  logic [DATA_W-1:0] cyc_data_q, cyc_data_d;
  logic [DATA_W-1:0] rsp_data_q, rsp_data_d;
  logic              wr_err_q, wr_err_d;
  logic              rd_pend_q, rd_pend_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  logic [ADDR_W-1:0] wb_addr_q [WBUF_DEPTH];
  logic [ADDR_W-1:0] wb_addr_d [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data_q [WBUF_DEPTH];
  logic [DATA_W-1:0] wb_data_d [WBUF_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]    wb_cnt_q, wb_cnt_d;

  logic wb_full;
  logic wb_empty;
  logic push;
  logic pop;
  logic rd_acc;

  assign wb_full  = (wb_cnt_q == WB_FULL);
  assign wb_empty = (wb_cnt_q == '0);

  // Readiness uses pre-pop state so a full buffer never accepts
  assign Req_Ready = Req_Wr ? !wb_full : !rd_pend_q;
  assign push      = Req_Valid && Req_Ready && Req_Wr;
  assign rd_acc    = Req_Valid && Req_Ready && !Req_Wr;

  // Next-state: bus FSM, wait counter, write buffer, read holding
  always_comb begin
    state_d    = state_q;
    wcnt_d     = wcnt_q;
    cyc_wr_d   = cyc_wr_q;
    cyc_err_d  = cyc_err_q;
    cyc_addr_d = cyc_addr_q;
    cyc_data_d = cyc_data_q;
    rsp_data_d = rsp_data_q;
    wr_err_d   = wr_err_q;
    rd_pend_d  = rd_pend_q;
    rd_addr_d  = rd_addr_q;
    wb_addr_d  = wb_addr_q;
    wb_data_d  = wb_data_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    wb_cnt_d   = wb_cnt_q;
    pop        = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        if (Bus_Grant) begin
          if (!wb_empty) begin
            pop        = 1'b1;
            state_d    = S_T1;
            cyc_wr_d   = 1'b1;
            cyc_addr_d = wb_addr_q[rd_ptr_q];
            cyc_data_d = wb_data_q[rd_ptr_q];
          end else if (rd_pend_q) begin
            state_d    = S_T1;
            cyc_wr_d   = 1'b0;
            cyc_addr_d = rd_addr_q;
            cyc_data_d = '0;
          end
        end
      end
      S_T1: begin
        state_d   = S_T2;
        wcnt_d    = '0;
        cyc_err_d = 1'b0;
      end
      S_T2: begin
        if (Bus_Ready) begin
          state_d = S_T3;
          if (!cyc_wr_q) rsp_data_d = Bus_D_In;
        end else if (TIMEOUT != 0 && wcnt_q == CNT_TO) begin
          state_d   = S_T3;
          cyc_err_d = 1'b1;
        end else if (wcnt_q != CNT_MAX) begin
          wcnt_d = wcnt_q + CNT_W'(1);
        end
      end
      S_T3: begin
        state_d = S_IDLE;
        if (!cyc_wr_q)      rd_pend_d = 1'b0;
        else if (cyc_err_q) wr_err_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_acc) begin
      rd_pend_d = 1'b1;
      rd_addr_d = Req_Addr;
    end

    if (push) begin
      wb_addr_d[wr_ptr_q] = Req_Addr;
      wb_data_d[wr_ptr_q] = Req_Data;
      wr_ptr_d            = wr_ptr_q + PTR_ONE;
    end
    if (pop) rd_ptr_d = rd_ptr_q + PTR_ONE;

    case ({push, pop})
      2'b10:   wb_cnt_d = wb_cnt_q + CNT_ONE;
      2'b01:   wb_cnt_d = wb_cnt_q - CNT_ONE;
      default: wb_cnt_d = wb_cnt_q;
    endcase
  end

  // State registers; reset aborts any cycle in flight
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      state_q    <= S_IDLE;
      wcnt_q     <= '0;
      cyc_wr_q   <= 1'b0;
      cyc_err_q  <= 1'b0;
      cyc_addr_q <= '0;
      cyc_data_q <= '0;
      rsp_data_q <= '0;
      wr_err_q   <= 1'b0;
      rd_pend_q  <= 1'b0;
      rd_addr_q  <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      wb_cnt_q   <= '0;
      for (int i = 0; i < WBUF_DEPTH; i++) begin
        wb_addr_q[i] <= '0;
        wb_data_q[i] <= '0;
      end
    end else begin
      state_q    <= state_d;
      wcnt_q     <= wcnt_d;
      cyc_wr_q   <= cyc_wr_d;
      cyc_err_q  <= cyc_err_d;
      cyc_addr_q <= cyc_addr_d;
      cyc_data_q <= cyc_data_d;
      rsp_data_q <= rsp_data_d;
      wr_err_q   <= wr_err_d;
      rd_pend_q  <= rd_pend_d;
      rd_addr_q  <= rd_addr_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      wb_cnt_q   <= wb_cnt_d;
      wb_addr_q  <= wb_addr_d;
      wb_data_q  <= wb_data_d;
    end
  end

  // Bus and response outputs decode straight from registered state
  always_comb begin
    Bus_Ale   = (state_q == S_T1);
    Bus_Addr  = cyc_addr_q;
    Bus_Rd_n  = !((state_q == S_T2) && !cyc_wr_q);
    Bus_Wr_n  = !((state_q == S_T2) && cyc_wr_q);
    Bus_D_Oe  = (state_q == S_T2) && cyc_wr_q;
    Bus_D_Out = Bus_D_Oe ? cyc_data_q : '0;
    Rsp_Valid = (state_q == S_T3) && !cyc_wr_q;
    Rsp_Err   = Rsp_Valid && cyc_err_q;
    Rsp_Data  = rsp_data_q;
    Wr_Err    = wr_err_q;
    Busy      = (state_q != S_IDLE) || !wb_empty || rd_pend_q;
  end

endmodule

// File: tb/tb_bus_interface_unit.sv
// Directed bench for bus_interface_unit with TIMEOUT=3.
// Expected values are hand-derived from the bus cycle timing.
module tb_bus_interface_unit;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_wr = 1'b0;
  logic [3:0] req_addr = '0;
  logic [3:0] req_data = '0;
  logic       rsp_valid;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic       wr_err;
  logic       bus_grant = 1'b1;
  logic       bus_ale;
  logic [3:0] bus_addr;
  logic [3:0] bus_d_out;
  logic       bus_d_oe;
  logic [3:0] bus_d_in = '0;
  logic       bus_rd_n;
  logic       bus_wr_n;
  logic       bus_ready = 1'b1;
  logic       busy;

  int n_chk = 0;
  int n_err = 0;

  int ale_cnt, wr_low, rd_low, rsp_cnt, oe_bad;
  int cyc, last_wr, first_rd, hold;
  logic [3:0] rsp_data_s;
  logic       rsp_err_s;
  logic       prev_wrlow;
  logic [3:0] prev_dout;
  logic [3:0] alog[$];
  logic [3:0] dlog[$];

  bus_interface_unit #(
    .DATA_W(4), .ADDR_W(4), .WBUF_DEPTH(4), .TIMEOUT(3)
  ) dut (
    .Clk(clk), .Rst(rst),
    .Req_Valid(req_valid), .Req_Ready(req_ready),
    .Req_Wr(req_wr), .Req_Addr(req_addr), .Req_Data(req_data),
    .Rsp_Valid(rsp_valid), .Rsp_Data(rsp_data), .Rsp_Err(rsp_err),
    .Wr_Err(wr_err), .Bus_Grant(bus_grant), .Bus_Ale(bus_ale),
    .Bus_Addr(bus_addr), .Bus_D_Out(bus_d_out), .Bus_D_Oe(bus_d_oe),
    .Bus_D_In(bus_d_in), .Bus_Rd_n(bus_rd_n), .Bus_Wr_n(bus_wr_n),
    .Bus_Ready(bus_ready), .Busy(busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic issue(input logic wr, input logic [3:0] a,
                       input logic [3:0] d, input string tag);
    tick();
    req_valid = 1'b1;
    req_wr    = wr;
    req_addr  = a;
    req_data  = d;
    chk(tag, 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
  endtask

  task automatic mon_clr();
    ale_cnt = 0; wr_low = 0; rd_low = 0; rsp_cnt = 0; oe_bad = 0;
    cyc = 0; last_wr = -1; first_rd = -1; hold = 0;
    rsp_data_s = '0; rsp_err_s = 1'b0;
    prev_wrlow = 1'b0; prev_dout = '0;
    alog.delete();
    dlog.delete();
  endtask

  task automatic mon(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      cyc++;
      if (bus_ale) begin
        ale_cnt++;
        alog.push_back(bus_addr);
      end
      if (!bus_wr_n) begin
        wr_low++;
        last_wr = cyc;
        if (!bus_d_oe) oe_bad++;
        if (!prev_wrlow) dlog.push_back(bus_d_out);
        else if (bus_d_out != prev_dout) oe_bad++;
      end
      if (!bus_rd_n) begin
        rd_low++;
        if (first_rd < 0) first_rd = cyc;
      end
      if (rsp_valid) begin
        rsp_cnt++;
        rsp_data_s = rsp_data;
        rsp_err_s  = rsp_err;
      end
      prev_wrlow = !bus_wr_n;
      prev_dout  = bus_d_out;
      if (!bus_rd_n || !bus_wr_n) begin
        if (hold > 0) begin
          bus_ready = 1'b0;
          hold--;
        end else begin
          bus_ready = 1'b1;
        end
      end else begin
        bus_ready = 1'b1;
      end
    end
  endtask

  initial begin
    // reset values
    tick();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rd_n",      32'(bus_rd_n),  32'd1);
    chk("rst_wr_n",      32'(bus_wr_n),  32'd1);
    chk("rst_oe",        32'(bus_d_oe),  32'd0);
    chk("rst_addr",      32'(bus_addr),  32'd0);
    chk("rst_busy",      32'(busy),      32'd0);
    rst = 1'b0;

    // 1: zero-wait read, cycle-by-cycle
    bus_grant = 1'b1;
    bus_ready = 1'b1;
    bus_d_in  = 4'h5;
    issue(1'b0, 4'hA, 4'h0, "t1_ready");
    chk("t1_c1_ale",  32'(bus_ale),   32'd0);
    chk("t1_c1_busy", 32'(busy),      32'd1);
    tick();
    chk("t1_c2_ale",  32'(bus_ale),   32'd1);
    chk("t1_c2_addr", 32'(bus_addr),  32'hA);
    chk("t1_c2_rdn",  32'(bus_rd_n),  32'd1);
    tick();
    chk("t1_c3_ale",  32'(bus_ale),   32'd0);
    chk("t1_c3_rdn",  32'(bus_rd_n),  32'd0);
    chk("t1_c3_addr", 32'(bus_addr),  32'hA);
    tick();
    chk("t1_c4_vld",  32'(rsp_valid), 32'd1);
    chk("t1_c4_data", 32'(rsp_data),  32'h5);
    chk("t1_c4_err",  32'(rsp_err),   32'd0);
    chk("t1_c4_rdn",  32'(bus_rd_n),  32'd1);
    tick();
    chk("t1_c5_vld",  32'(rsp_valid), 32'd0);
    chk("t1_c5_busy", 32'(busy),      32'd0);

    // 2: write with two wait states
    issue(1'b1, 4'h2, 4'h3, "t2_ready");
    mon_clr();
    hold = 2;
    mon(8);
    chk("t2_wr_low", 32'(wr_low),  32'd3);
    chk("t2_oe_bad", 32'(oe_bad),  32'd0);
    chk("t2_ale",    32'(ale_cnt), 32'd1);
    chk("t2_addr",   32'(alog.size() > 0 ? alog[0] : 4'hF), 32'h2);
    chk("t2_dout",   32'(dlog.size() > 0 ? dlog[0] : 4'hF), 32'h3);
    chk("t2_wr_err", 32'(wr_err),  32'd0);
    chk("t2_busy",   32'(busy),    32'd0);

    // 3: fill buffer without grant, then drain in order
    bus_grant = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      req_valid = 1'b1;
      req_wr    = 1'b1;
      req_addr  = 4'(i);
      req_data  = 4'(i + 8);
      chk($sformatf("t3_ready%0d", i), 32'(req_ready), 32'd1);
    end
    tick();
    req_addr = 4'hE;
    req_data = 4'hE;
    chk("t3_full", 32'(req_ready), 32'd0);
    tick();
    req_valid = 1'b0;
    chk("t3_busy", 32'(busy),    32'd1);
    chk("t3_noale", 32'(bus_ale), 32'd0);
    bus_grant = 1'b1;
    mon_clr();
    mon(24);
    chk("t3_ale_cnt", 32'(ale_cnt), 32'd4);
    chk("t3_wr_low",  32'(wr_low),  32'd4);
    chk("t3_oe_bad",  32'(oe_bad),  32'd0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("t3_addr%0d", i),
          32'(alog.size() > i ? alog[i] : 4'hF), 32'(i));
      chk($sformatf("t3_data%0d", i),
          32'(dlog.size() > i ? dlog[i] : 4'hF), 32'(i + 8));
    end
    chk("t3_idle", 32'(busy), 32'd0);

    // 4: read-after-write ordering to the same address
    bus_grant = 1'b0;
    bus_d_in  = 4'h9;
    issue(1'b1, 4'h7, 4'h6, "t4_wr_ready");
    issue(1'b0, 4'h7, 4'h0, "t4_rd_ready");
    bus_grant = 1'b1;
    mon_clr();
    mon(16);
    chk("t4_order", 32'(first_rd > 0 && last_wr > 0 && last_wr < first_rd),
        32'd1);
    chk("t4_rsp_cnt",  32'(rsp_cnt),    32'd1);
    chk("t4_rsp_data", 32'(rsp_data_s), 32'h9);
    chk("t4_dout",     32'(dlog.size() > 0 ? dlog[0] : 4'hF), 32'h6);

    // 5: timeout on read, then on write (sticky)
    issue(1'b0, 4'h4, 4'h0, "t5_rd_ready");
    mon_clr();
    hold = 100;
    mon(10);
    chk("t5_rd_low",  32'(rd_low),    32'd4);
    chk("t5_rsp_cnt", 32'(rsp_cnt),   32'd1);
    chk("t5_rsp_err", 32'(rsp_err_s), 32'd1);
    chk("t5_wr_err0", 32'(wr_err),    32'd0);
    issue(1'b1, 4'h5, 4'h1, "t5_wr_ready");
    mon_clr();
    hold = 100;
    mon(10);
    chk("t5_wr_low",  32'(wr_low), 32'd4);
    chk("t5_wr_err1", 32'(wr_err), 32'd1);
    issue(1'b1, 4'h6, 4'h2, "t5_wr2_ready");
    mon_clr();
    mon(8);
    chk("t5_wr2_low", 32'(wr_low), 32'd1);
    chk("t5_sticky",  32'(wr_err), 32'd1);

    // 6: asynchronous reset in the middle of T2
    issue(1'b0, 4'h1, 4'h0, "t6_ready");
    bus_ready = 1'b0;
    tick();
    tick();
    chk("t6_in_t2", 32'(bus_rd_n), 32'd0);
    #2;
    rst = 1'b1;
    #1;
    chk("t6_rd_n",   32'(bus_rd_n),  32'd1);
    chk("t6_wr_n",   32'(bus_wr_n),  32'd1);
    chk("t6_oe",     32'(bus_d_oe),  32'd0);
    chk("t6_busy",   32'(busy),      32'd0);
    chk("t6_vld",    32'(rsp_valid), 32'd0);
    chk("t6_wr_err", 32'(wr_err),    32'd0);
    chk("t6_data",   32'(rsp_data),  32'd0);
    tick();
    chk("t6_vld_r1", 32'(rsp_valid), 32'd0);
    tick();
    rst = 1'b0;
    bus_ready = 1'b1;
    mon_clr();
    mon(8);
    chk("t6_no_rsp", 32'(rsp_cnt), 32'd0);
    chk("t6_no_ale", 32'(ale_cnt), 32'd0);
    chk("t6_idle",   32'(busy),    32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
